// File: rtl/prng_seq_if.sv
// Byte-pipe bundle between prng_seq and the xoroshiro PRNG plus the result sink.
// Signal names are seen from the sequencer: o_* are driven by it, i_* are
// driven by the PRNG (command ready, response byte) or by the stream sink.
//   o_m_data/o_m_valid/i_m_ready : command/data bytes to the PRNG
//   i_m_data/i_m_valid/o_m_ready : response bytes from the PRNG
//   o_s_data/o_s_valid/i_s_ready : forwarded result byte stream
interface prng_seq_if;
    logic [7:0] o_m_data;
    logic       o_m_valid;
    logic       i_m_ready;
    logic [7:0] i_m_data;
    logic       i_m_valid;
    logic       o_m_ready;
    logic [7:0] o_s_data;
    logic       o_s_valid;
    logic       i_s_ready;

    // Sequencer side.
    modport master (
        output o_m_data, o_m_valid, o_m_ready, o_s_data, o_s_valid,
        input  i_m_ready, i_m_data, i_m_valid, i_s_ready
    );

    // PRNG and stream-sink side.
    modport slave (
        input  o_m_data, o_m_valid, o_m_ready, o_s_data, o_s_valid,
        output i_m_ready, i_m_data, i_m_valid, i_s_ready
    );
endinterface

// File: rtl/prng_seq.sv
// Sole master of the xoroshiro byte-pipe: on start, optionally shifts a 128b
// seed in as 16 single-byte writes (MSB first), then issues i_nRead single-byte
// reads and forwards each result byte to the downstream stream.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset (shared with PRNG)
//   i_cg              clock gate; low freezes all state and blocks handshakes
//   i_start/i_seedEn  start pulse (IDLE only) and seed-phase enable
//   i_seed/i_nRead    seed and read count, captured at start
//   i_abort           sticky early-stop request
//   o_busy/o_done     not-IDLE flag and one-cycle completion pulse
//   bus               command, response and result stream handshakes
module prng_seq #(
    parameter logic [6:0]  SEED_ADDR = 7'd1,
    parameter logic [6:0]  READ_ADDR = 7'd2,
    parameter int unsigned N_W       = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_cg,
    input  logic           i_start,
    input  logic           i_seedEn,
    input  logic [127:0]   i_seed,
    input  logic [N_W-1:0] i_nRead,
    input  logic           i_abort,
    output logic           o_busy,
    output logic           o_done,
    prng_seq_if.master     bus
);
    localparam int unsigned SEED_W = 128;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SCNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED_CMD,
        S_SEED_DAT,
        S_SEED_RSP,
        S_RD_CMD,
        S_RD_RSP,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEED_W-1:0]   r_seed;
    logic [SEED_W-1:0]   w_seed_nxt;
    logic [N_W-1:0]      r_nread;
    logic [N_W-1:0]      w_nread_nxt;
    logic [SCNT_W-1:0]   r_seed_cnt;
    logic [SCNT_W-1:0]   w_seed_cnt_nxt;
    logic                r_abort;
    logic                w_abort_nxt;
    logic                w_abort_any;
    logic                r_m_valid;
    logic [BYTE_W-1:0]   r_m_data;
    logic [BYTE_W-1:0]   w_m_data_nxt;
    logic                w_cmd_acc;
    logic                w_rsp_acc;

    assign w_cmd_acc   = r_m_valid && bus.i_m_ready && i_cg;
    assign w_rsp_acc   = bus.o_m_ready && bus.i_m_valid && i_cg;
    assign w_abort_any = r_abort || i_abort;

    assign bus.o_m_valid = r_m_valid;
    assign bus.o_m_data  = r_m_data;

    // Response side: seed acks are swallowed, read results pass straight through.
    always_comb begin
        bus.o_m_ready = 1'b0;
        bus.o_s_valid = 1'b0;
        bus.o_s_data  = '0;
        if (r_state == S_SEED_RSP) begin
            bus.o_m_ready = 1'b1;
        end else if (r_state == S_RD_RSP) begin
            bus.o_m_ready = bus.i_s_ready;
            bus.o_s_valid = bus.i_m_valid;
            bus.o_s_data  = bus.i_m_data;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        w_state_nxt    = r_state;
        w_seed_nxt     = r_seed;
        w_nread_nxt    = r_nread;
        w_seed_cnt_nxt = r_seed_cnt;
        w_abort_nxt    = w_abort_any;
        case (r_state)
            S_IDLE: begin
                // Abort is cleared here; a coincident start wins over it.
                w_abort_nxt = 1'b0;
                if (i_start) begin
                    w_seed_nxt     = i_seed;
                    w_nread_nxt    = i_nRead;
                    w_seed_cnt_nxt = '0;
                    if (i_seedEn)
                        w_state_nxt = S_SEED_CMD;
                    else if (i_nRead != '0)
                        w_state_nxt = S_RD_CMD;
                    else
                        w_state_nxt = S_DONE;
                end
            end
            S_SEED_CMD: begin
                // An accepted command commits us to finishing the write.
                if (w_cmd_acc)
                    w_state_nxt = S_SEED_DAT;
                else if (w_abort_any)
                    w_state_nxt = S_DONE;
            end
            S_SEED_DAT: begin
                if (w_cmd_acc) begin
                    w_seed_nxt  = {r_seed[SEED_W-BYTE_W-1:0], BYTE_W'(0)};
                    w_state_nxt = S_SEED_RSP;
                end
            end
            S_SEED_RSP: begin
                if (w_rsp_acc) begin
                    w_seed_cnt_nxt = r_seed_cnt + SCNT_W'(1);
                    if (w_abort_any)
                        w_state_nxt = S_DONE;
                    else if (r_seed_cnt == SCNT_W'(15))
                        w_state_nxt = (r_nread != '0) ? S_RD_CMD : S_DONE;
                    else
                        w_state_nxt = S_SEED_CMD;
                end
            end
            S_RD_CMD: begin
                if (w_cmd_acc)
                    w_state_nxt = S_RD_RSP;
                else if (w_abort_any)
                    w_state_nxt = S_DONE;
            end
            S_RD_RSP: begin
                if (w_rsp_acc) begin
                    w_nread_nxt = r_nread - N_W'(1);
                    if (w_abort_any || (r_nread == N_W'(1)))
                        w_state_nxt = S_DONE;
                    else
                        w_state_nxt = S_RD_CMD;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Command byte presented in the state being entered.
    always_comb begin
        w_m_data_nxt = '0;
        case (w_state_nxt)
            S_SEED_CMD: w_m_data_nxt = {1'b1, SEED_ADDR};
            S_SEED_DAT: w_m_data_nxt = w_seed_nxt[SEED_W-1 -: BYTE_W];
            S_RD_CMD:   w_m_data_nxt = {1'b0, READ_ADDR};
            default:    w_m_data_nxt = '0;
        endcase
    end

    // State, counters and registered outputs; everything holds while i_cg is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_seed     <= '0;
            r_nread    <= '0;
            r_seed_cnt <= '0;
            r_abort    <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else if (i_cg) begin
            r_state    <= w_state_nxt;
            r_seed     <= w_seed_nxt;
            r_nread    <= w_nread_nxt;
            r_seed_cnt <= w_seed_cnt_nxt;
            r_abort    <= w_abort_nxt;
            r_m_valid  <= (w_state_nxt == S_SEED_CMD) || (w_state_nxt == S_SEED_DAT) ||
                          (w_state_nxt == S_RD_CMD);
            r_m_data   <= w_m_data_nxt;
            o_busy     <= (w_state_nxt != S_IDLE);
            o_done     <= (w_state_nxt == S_DONE);
        end
    end
endmodule

// File: tb/tb_prng_seq.sv
// Bench for prng_seq: a behavioural PRNG/sink responder plus a transaction-level
// model (expected command bytes, expected stream bytes, outstanding responses).
module tb_prng_seq;
    localparam int unsigned N_W = 8;

    logic           clk     = 1'b0;
    logic           rst     = 1'b1;
    logic           cg      = 1'b1;
    logic           start   = 1'b0;
    logic           seed_en = 1'b0;
    logic [127:0]   seed    = '0;
    logic [N_W-1:0] n_read  = '0;
    logic           abort   = 1'b0;
    logic           busy;
    logic           done;

    prng_seq_if bus();

    prng_seq #(.SEED_ADDR(7'd1), .READ_ADDR(7'd2), .N_W(N_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_start(start), .i_seedEn(seed_en),
        .i_seed(seed), .i_nRead(n_read), .i_abort(abort), .o_busy(busy), .o_done(done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state.
    logic [7:0] exp_cmd[$];
    logic [7:0] exp_str[$];
    logic [7:0] got_cmd[$];
    logic [7:0] got_str[$];
    int         rsp_left  = 0;
    int         rd_k      = 0;
    int         done_cnt  = 0;
    bit         done_due  = 1'b0;
    bit         prev_done = 1'b0;

    // Handshakes seen before a posedge, consumed by the responder afterwards.
    bit         ck_rst      = 1'b1;
    bit         ck_hs_cmd   = 1'b0;
    bit         ck_hs_rsp   = 1'b0;
    logic [7:0] ck_cmd_byte = '0;

    // Responder controls.
    bit m_stall_mode = 1'b0;
    bit s_toggle_mode = 1'b0;
    int sl_rd = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte the responder returns for its k-th read.
    function automatic logic [7:0] rd_byte(int k);
        return 8'(k * 37 + 11);
    endfunction

    // Expected traffic: seed pairs {0x81, byte} MSB first, then n reads of 0x02.
    task automatic plan(logic [127:0] s, bit en, int pairs, int n);
        got_cmd.delete();
        got_str.delete();
        if (en) begin
            for (int i = 0; i < pairs; i++) begin
                exp_cmd.push_back(8'h81);
                exp_cmd.push_back(s[127 - 8*i -: 8]);
            end
        end
        for (int k = 0; k < n; k++) begin
            exp_cmd.push_back(8'h02);
            exp_str.push_back(rd_byte(rd_k + k));
        end
        rsp_left = (en ? pairs : 0) + n;
        rd_k += n;
    endtask

    // Compare process: sample every cycle at negedge + 2.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            ck_rst    = rst;
            ck_hs_cmd = 1'b0;
            ck_hs_rsp = 1'b0;
            if (!rst) begin
                if (done_due) begin
                    chk("done_after_last_rsp", done, 1'b1);
                    done_due = 1'b0;
                end
                if (prev_done) chk("idle_after_done", {busy, done}, 0);
                prev_done = done && cg;
                if (exp_cmd.size() == 0) chk("m_valid_unexpected", bus.o_m_valid, 1'b0);
                else if (bus.o_m_valid) chk("m_data", bus.o_m_data, exp_cmd[0]);
                if (exp_str.size() == 0) chk("s_valid_unexpected", bus.o_s_valid, 1'b0);
                else if (bus.o_s_valid) chk("s_data", bus.o_s_data, exp_str[0]);
                if (rsp_left == 0) chk("m_ready_unexpected", bus.o_m_ready, 1'b0);
                ck_hs_cmd   = bus.o_m_valid && bus.i_m_ready && cg;
                ck_hs_rsp   = bus.o_m_ready && bus.i_m_valid && cg;
                ck_cmd_byte = bus.o_m_data;
                if (ck_hs_cmd) begin
                    got_cmd.push_back(bus.o_m_data);
                    if (exp_cmd.size() != 0) void'(exp_cmd.pop_front());
                end
                if (bus.o_s_valid && bus.i_s_ready && cg) begin
                    got_str.push_back(bus.o_s_data);
                    if (exp_str.size() != 0) void'(exp_str.pop_front());
                end
                if (ck_hs_rsp) begin
                    chk("rsp_expected", rsp_left > 0, 1'b1);
                    if (rsp_left > 0) begin
                        rsp_left--;
                        if (rsp_left == 0) done_due = 1'b1;
                    end
                end
                if (done) begin
                    chk("done_cmd_left", exp_cmd.size(), 0);
                    chk("done_str_left", exp_str.size(), 0);
                    chk("done_rsp_left", rsp_left, 0);
                    chk("done_busy", busy, 1'b1);
                    done_cnt++;
                end
            end else begin
                prev_done = 1'b0;
                done_due  = 1'b0;
            end
        end
    end

    // PRNG and sink responder: one outstanding transaction, ack 0xEE for writes.
    initial begin
        bit phase;
        int stall;
        bit tog;
        phase = 1'b0;
        stall = 0;
        tog   = 1'b0;
        bus.i_m_ready = 1'b0;
        bus.i_m_valid = 1'b0;
        bus.i_m_data  = '0;
        bus.i_s_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (ck_rst) begin
                bus.i_m_valid = 1'b0;
                phase = 1'b0;
                stall = 0;
            end else begin
                if (ck_hs_rsp) bus.i_m_valid = 1'b0;
                if (ck_hs_cmd) begin
                    stall = 0;
                    if (!phase && ck_cmd_byte[7]) begin
                        phase = 1'b1;
                    end else if (!phase) begin
                        bus.i_m_valid = 1'b1;
                        bus.i_m_data  = rd_byte(sl_rd);
                        sl_rd++;
                    end else begin
                        phase = 1'b0;
                        bus.i_m_valid = 1'b1;
                        bus.i_m_data  = 8'hEE;
                    end
                end
            end
            if (m_stall_mode) begin
                if (bus.o_m_valid && stall >= 2) begin
                    bus.i_m_ready = 1'b1;
                end else begin
                    bus.i_m_ready = 1'b0;
                    if (bus.o_m_valid) stall++;
                end
            end else begin
                bus.i_m_ready = 1'b1;
            end
            tog = ~tog;
            bus.i_s_ready = s_toggle_mode ? tog : 1'b1;
        end
    end

    task automatic launch(logic [127:0] s, bit en, int n);
        seed    = s;
        seed_en = en;
        n_read  = N_W'(n);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic run_to_done(string name, int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        chk({name, "_done_pulses"}, done_cnt - d0, 1);
        chk({name, "_busy_after"}, busy, 1'b0);
    endtask

    task automatic chk_outputs_zero(string name);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_done"}, done, 1'b0);
        chk({name, "_m_valid"}, bus.o_m_valid, 1'b0);
        chk({name, "_m_ready"}, bus.o_m_ready, 1'b0);
        chk({name, "_s_valid"}, bus.o_s_valid, 1'b0);
        chk({name, "_m_data"}, bus.o_m_data, 8'h00);
    endtask

    initial begin
        int k;
        // Reset state.
        repeat (3) @(negedge clk);
        #3;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Seed-only run.
        plan(128'h0123456789ABCDEF_0123456789ABCDEF, 1'b1, 16, 0);
        launch(128'h0123456789ABCDEF_0123456789ABCDEF, 1'b1, 0);
        run_to_done("seed", 300);
        chk("seed_cmd_count", got_cmd.size(), 32);
        chk("seed_b0_cmd", got_cmd[0], 8'h81);
        chk("seed_b0_dat", got_cmd[1], 8'h01);
        chk("seed_b1_dat", got_cmd[3], 8'h23);
        chk("seed_b15_cmd", got_cmd[30], 8'h81);
        chk("seed_b15_dat", got_cmd[31], 8'hEF);
        chk("seed_no_stream", got_str.size(), 0);

        // Four reads, sink always ready.
        plan('0, 1'b0, 0, 4);
        launch('0, 1'b0, 4);
        run_to_done("rd4", 200);
        chk("rd4_cmd_count", got_cmd.size(), 4);
        chk("rd4_cmd3", got_cmd[3], 8'h02);
        chk("rd4_s0", got_str[0], 8'h0B);
        chk("rd4_s1", got_str[1], 8'h30);
        chk("rd4_s2", got_str[2], 8'h55);
        chk("rd4_s3", got_str[3], 8'h7A);

        // Three reads under command stalls and a toggling sink.
        m_stall_mode  = 1'b1;
        s_toggle_mode = 1'b1;
        plan('0, 1'b0, 0, 3);
        launch('0, 1'b0, 3);
        run_to_done("stall", 300);
        m_stall_mode  = 1'b0;
        s_toggle_mode = 1'b0;
        chk("stall_str_count", got_str.size(), 3);
        chk("stall_s0", got_str[0], 8'h9F);
        chk("stall_s1", got_str[1], 8'hC4);
        chk("stall_s2", got_str[2], 8'hE9);

        // Abort while the sixth seed data byte is pending.
        plan(128'h00112233445566778899AABBCCDDEEFF, 1'b1, 6, 0);
        launch(128'h00112233445566778899AABBCCDDEEFF, 1'b1, 5);
        k = 0;
        while (got_cmd.size() < 11 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("abort_reached_dat5", got_cmd.size(), 11);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        run_to_done("abort", 100);
        chk("abort_cmd_count", got_cmd.size(), 12);
        chk("abort_dat5", got_cmd[11], 8'h55);

        // Clock gate low for 10 cycles with a read response pending.
        plan('0, 1'b0, 0, 4);
        launch('0, 1'b0, 4);
        k = 0;
        while (got_cmd.size() < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        cg = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("cg_busy_held", busy, 1'b1);
            chk("cg_stream_frozen", got_str.size(), 1);
        end
        cg = 1'b1;
        run_to_done("cg", 200);
        chk("cg_str_count", got_str.size(), 4);
        chk("cg_s1", got_str[1], 8'h33);

        // Reset while RD_CMD holds o_m_valid under a stall.
        m_stall_mode = 1'b1;
        plan('0, 1'b0, 0, 2);
        launch('0, 1'b0, 2);
        k = 0;
        while (!bus.o_m_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("rst_saw_valid", bus.o_m_valid, 1'b1);
        rst = 1'b1;
        exp_cmd.delete();
        exp_str.delete();
        rsp_left = 0;
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk_outputs_zero("midrst");
        rd_k = sl_rd;
        m_stall_mode = 1'b0;
        @(negedge clk);
        plan('0, 1'b0, 0, 2);
        launch('0, 1'b0, 2);
        run_to_done("postrst", 200);
        chk("postrst_str_count", got_str.size(), 2);

        // Maximum read count for this counter width.
        plan('0, 1'b0, 0, 255);
        launch('0, 1'b0, 255);
        run_to_done("maxcnt", 2000);
        chk("maxcnt_str_count", got_str.size(), 255);
        chk("maxcnt_cmd_count", got_cmd.size(), 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
